ram512_dma: RTL and testbench
=============================

Name: ram512_dma

Overview:
- Initiator and master for a RAM512-style memory port: drives address, write data and load, and samples the combinational read data.
- Performs block copy (memory-to-memory) and block fill (constant-to-memory) over the 512-word, 16-bit space.
- Sits between the CPU/control logic and a RAM512 instance, so bulk moves do not need a software loop.

Parameters:
- AW, 9, address width; memory depth is 2^AW words.
- DW, 16, data word width.
- LW, 10, length field width; must hold the value 2^AW.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- op  input  1  0 = copy, 1 = fill.
- src_addr  input  AW  copy source base (ignored for fill).
- dst_addr  input  AW  destination base.
- length  input  LW  word count, 0..512; values >512 are clamped to 512.
- fill_data  input  DW  fill constant.
- busy  output  1  high from the cycle after accepted start until DONE.
- done  output  1  one-cycle pulse when the command completes.
- words_done  output  LW  count of words written so far for the current command.
- mem_address  output  AW  memory address.
- mem_in  output  DW  memory write data.
- mem_load  output  1  memory write strobe.
- mem_out  input  DW  memory read data, combinational from mem_address.

Behaviour:
- Reset (synchronous): state=IDLE. busy=0, done=0, mem_load=0, mem_address=0, mem_in=0, words_done=0. Reset mid-command aborts immediately; partial writes already made remain.
- All outputs are registered. mem_address and mem_in change only on edges where mem_load is 0 in the preceding cycle, or together with mem_load rising. While mem_load=1 they are stable for that whole cycle.
- mem_load is high for exactly one cycle per word, then low for at least the following cycle (copy) or may stay high on back-to-back fill writes. Address/data change only at edges, so each write is single-edge safe.
- State machine: IDLE, RD, WR, FILL, DONE.
- IDLE: on start=1, latch op, src, dst, length (clamped, as count), fill_data, and clear index i=0.
  - If count=0, go to DONE.
  - Else go to RD (copy) or FILL (fill).
  - busy=1 from the next cycle.
- RD (copy): mem_address=src+i, mem_load=0. At the end of the cycle capture mem_out into the data register, then go to WR.
- WR (copy): mem_address=dst+i, mem_in=captured data, mem_load=1. Increment i and words_done.
  - If i+1==count, go to DONE.
  - Else go to RD.
  - Copy throughput: 2 cycles per word, so N words take 2N busy cycles.
- FILL: mem_address=dst+i, mem_in=fill_data, mem_load=1 every cycle. Increment i.
  - If i+1==count, go to DONE.
  - Throughput: 1 word per cycle.
- DONE: busy=0, done=1 for this cycle only, mem_load=0, then go to IDLE. words_done holds its final value until the next accepted start.
- Address arithmetic is modulo 2^AW: src+i and dst+i wrap from 511 to 0.
- Overlap: the copy runs in strictly ascending order. With dst within (src, src+count) data propagates forward. This is the specified behaviour; no memmove semantics.
- start while busy or in DONE is ignored (not queued).
- Command inputs are don't-care except on the accepting edge.

Decomposition:
- Shared package hack_mem_pkg holds:
  - AW, DW, LW constants;
  - RAM_DEPTH=512;
  - op encodings OP_COPY=0 and OP_FILL=1;
  - the state enum (IDLE, RD, WR, FILL, DONE).
- No sub-module. The address adder/wrap is inline; a single FSM plus counter is natural.
- The bench instantiates ram512_dma against the existing RAM512 as the memory model.

Test Plan:
- Fill dst=10, length=4, fill_data=0xBEEF -> mem_load high for 4 consecutive cycles at addresses 10..13; done pulses once; busy lasts 4 cycles; words_done=4; RAM[10..13]=0xBEEF, RAM[9] and RAM[14] unchanged.
- Copy src=0, dst=100, length=3 with RAM[0..2]=1,2,3 -> address sequence 0,100,1,101,2,102 with load on odd steps only; RAM[100..102]=1,2,3; busy for 6 cycles.
- Wrap: fill dst=510, length=4, value 0x0007 -> writes at 510, 511, 0, 1; copy src=511, dst=5, length=2 reads 511, 0.
- length=0 and length=600 -> length 0 gives done one cycle after start, with no mem_load and words_done=0; length 600 writes exactly 512 words.
- Overlapping copy src=20, dst=21, length=3 with RAM[20]=0xA -> RAM[21..23]=0xA; start pulsed mid-command is ignored.
- Reset asserted in the 3rd cycle of a 5-word fill -> next cycle mem_load=0, busy=0, done=0, words_done=0; only the first 2 words are written.

Source files
------------

// File: rtl/hack_mem_pkg.sv
// ---------------------------------------------------------------------------
// hack_mem_pkg
// Shared constants and types for the RAM512 block-move engine.
//   AW        : address width (512-word space)
//   DW        : data word width
//   LW        : length/count width, wide enough to hold RAM_DEPTH itself
//   RAM_DEPTH : number of words in the memory
//   OP_COPY / OP_FILL : encodings of the op input
//   dma_state_t       : controller states
//   clamp_length()    : limits a requested length to RAM_DEPTH
// ---------------------------------------------------------------------------
package hack_mem_pkg;

    localparam int AW        = 9;
    localparam int DW        = 16;
    localparam int LW        = 10;
    localparam int RAM_DEPTH = 512;

    localparam logic OP_COPY = 1'b0;
    localparam logic OP_FILL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        FILL,
        DONE
    } dma_state_t;

    // A request longer than the whole memory can only ever touch every word
    // once, so anything beyond RAM_DEPTH is treated as exactly RAM_DEPTH.
    function automatic logic [LW-1:0] clamp_length(input logic [LW-1:0] len);
        if (len > LW'(RAM_DEPTH)) begin
            return LW'(RAM_DEPTH);
        end
        return len;
    endfunction

endpackage

// File: rtl/ram512_dma.sv
// ---------------------------------------------------------------------------
// ram512_dma
// Block copy / block fill engine that masters a RAM512-style memory port.
// Copy moves 'length' words from src_addr to dst_addr in ascending order,
// two cycles per word (read, then write). Fill writes fill_data to 'length'
// words starting at dst_addr, one word per cycle. Addresses wrap modulo 512.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, op           : command strobe (taken only when idle), 0=copy 1=fill
//   src_addr, dst_addr  : base addresses of the command
//   length              : word count, 0..512 (larger values clamp to 512)
//   fill_data           : constant written by a fill
//   busy, done          : command in progress / one-cycle completion pulse
//   words_done          : words written so far by the current command
//   mem_address, mem_in, mem_load : memory address, write data, write strobe
//   mem_out             : combinational read data from the memory
// ---------------------------------------------------------------------------
module ram512_dma
    import hack_mem_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          op,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] length,
    input  logic [DW-1:0] fill_data,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] words_done,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_in,
    output logic          mem_load,
    input  logic [DW-1:0] mem_out
);

    dma_state_t    state, state_next;

    logic [AW-1:0] src_base, src_base_next;
    logic [AW-1:0] dst_base, dst_base_next;
    logic [LW-1:0] count, count_next;
    logic [DW-1:0] fill_value, fill_value_next;
    logic [LW-1:0] idx, idx_next;

    logic          busy_next;
    logic          done_next;
    logic [LW-1:0] words_done_next;
    logic [AW-1:0] mem_address_next;
    logic [DW-1:0] mem_in_next;
    logic          mem_load_next;

    logic [LW-1:0] idx_plus;
    logic [LW-1:0] req_count;
    logic          last_word;

    assign idx_plus  = idx + LW'(1);
    assign req_count = clamp_length(length);
    assign last_word = (idx_plus == count);

    // Every output is a register. The combinational block below works out
    // what each output must show during the *next* cycle, so the memory
    // port sees an address, data and strobe that are stable for a whole
    // cycle and only move at clock edges. The op bit is not kept after
    // acceptance because the chosen state (RD vs FILL) already records it.
    always_comb begin
        state_next       = state;
        src_base_next    = src_base;
        dst_base_next    = dst_base;
        count_next       = count;
        fill_value_next  = fill_value;
        idx_next         = idx;
        busy_next        = busy;
        done_next        = 1'b0;
        words_done_next  = words_done;
        mem_address_next = mem_address;
        mem_in_next      = mem_in;
        mem_load_next    = 1'b0;

        case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (start) begin
                    src_base_next   = src_addr;
                    dst_base_next   = dst_addr;
                    count_next      = req_count;
                    fill_value_next = fill_data;
                    idx_next        = '0;
                    words_done_next = '0;
                    if (req_count == '0) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else if (op == OP_FILL) begin
                        state_next       = FILL;
                        busy_next        = 1'b1;
                        mem_address_next = dst_addr;
                        mem_in_next      = fill_data;
                        mem_load_next    = 1'b1;
                    end else begin
                        state_next       = RD;
                        busy_next        = 1'b1;
                        mem_address_next = src_addr;
                    end
                end
            end

            // The read address has been on the port for a full cycle, so
            // mem_out is valid here; it goes straight into the write-data
            // register, which doubles as the copy's holding register.
            RD: begin
                state_next       = WR;
                mem_address_next = dst_base + idx[AW-1:0];
                mem_in_next      = mem_out;
                mem_load_next    = 1'b1;
            end

            // The write happens at the edge that leaves this state, which
            // is also when the word is counted.
            WR: begin
                idx_next        = idx_plus;
                words_done_next = words_done + LW'(1);
                if (last_word) begin
                    state_next = DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    state_next       = RD;
                    mem_address_next = src_base + idx_plus[AW-1:0];
                end
            end

            // Back-to-back writes: the strobe stays high and the address
            // steps at each edge, each edge committing one word.
            FILL: begin
                idx_next        = idx_plus;
                words_done_next = words_done + LW'(1);
                if (last_word) begin
                    state_next = DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    mem_address_next = dst_base + idx_plus[AW-1:0];
                    mem_in_next      = fill_value;
                    mem_load_next    = 1'b1;
                end
            end

            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State register. Reset abandons any command on the spot; words that
    // were already committed to memory stay there.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command latches, word index and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_base    <= '0;
            dst_base    <= '0;
            count       <= '0;
            fill_value  <= '0;
            idx         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            words_done  <= '0;
            mem_address <= '0;
            mem_in      <= '0;
            mem_load    <= 1'b0;
        end else begin
            src_base    <= src_base_next;
            dst_base    <= dst_base_next;
            count       <= count_next;
            fill_value  <= fill_value_next;
            idx         <= idx_next;
            busy        <= busy_next;
            done        <= done_next;
            words_done  <= words_done_next;
            mem_address <= mem_address_next;
            mem_in      <= mem_in_next;
            mem_load    <= mem_load_next;
        end
    end

endmodule

// File: tb/tb_ram512_dma.sv
// ---------------------------------------------------------------------------
// tb_ram512_dma
// Drives ram512_dma against a behavioural 512x16 RAM with combinational read
// and clocked write. A reference memory image is updated word by word from
// the command semantics (ascending copy / fill, addresses modulo 512), and
// the bus activity seen during busy is compared against the expected
// address/strobe sequence for the command.
// ---------------------------------------------------------------------------
module tb_ram512_dma;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [8:0]  src_addr;
    logic [8:0]  dst_addr;
    logic [9:0]  length;
    logic [15:0] fill_data;
    logic        busy;
    logic        done;
    logic [9:0]  words_done;
    logic [8:0]  mem_address;
    logic [15:0] mem_in;
    logic        mem_load;
    logic [15:0] mem_out;

    logic [15:0] ram    [DEPTH];
    logic [15:0] refMem [DEPTH];

    logic        bdWe = 1'b0;
    logic [8:0]  bdAddr = '0;
    logic [15:0] bdData = '0;

    int checks = 0;
    int errors = 0;

    logic [8:0] addrQ [$];
    bit         loadQ [$];
    int         doneCount = 0;
    int         strayLoads = 0;

    always #5 clk = ~clk;

    ram512_dma dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .fill_data  (fill_data),
        .busy       (busy),
        .done       (done),
        .words_done (words_done),
        .mem_address(mem_address),
        .mem_in     (mem_in),
        .mem_load   (mem_load),
        .mem_out    (mem_out)
    );

    // Behavioural RAM512: combinational read, write on the rising edge.
    // The backdoor port is only used while the engine is idle.
    assign mem_out = ram[mem_address];

    always @(posedge clk) begin
        if (bdWe) begin
            ram[bdAddr] <= bdData;
        end else if (mem_load) begin
            ram[mem_address] <= mem_in;
        end
    end

    // Bus monitor: records the address/strobe of every busy cycle, counts
    // done pulses and any write strobe seen outside busy.
    always @(negedge clk) begin
        if (busy) begin
            addrQ.push_back(mem_address);
            loadQ.push_back(mem_load);
        end
        if (mem_load && !busy) begin
            strayLoads++;
        end
        if (done) begin
            doneCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic pokeWord(input int addr, input logic [15:0] data);
        @(negedge clk);
        bdWe   = 1'b1;
        bdAddr = addr[8:0];
        bdData = data;
        refMem[addr] = data;
        @(negedge clk);
        bdWe = 1'b0;
    endtask

    task automatic preloadRandom();
        logic [15:0] v;
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            v      = 16'($urandom);
            bdWe   = 1'b1;
            bdAddr = a[8:0];
            bdData = v;
            refMem[a] = v;
        end
        @(negedge clk);
        bdWe = 1'b0;
    endtask

    task automatic checkMemory(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            checkOutput($sformatf("%s mem[%0d]", tag, a), 32'(ram[a]), 32'(refMem[a]));
        end
    endtask

    // Issues one command, waits (bounded) for done, then checks timing,
    // counters, the bus trace and the whole memory image against the model.
    // With pokeMid set, a conflicting start is pulsed while busy.
    task automatic applyStimulus(input string name, input bit isFill, input int src,
                                 input int dst, input int len, input logic [15:0] fv,
                                 input bit pokeMid);
        int n;
        int expBusy;
        int a0;
        int d0;
        int s0;
        int waitCycles;
        int nTrace;
        bit seen;
        int expAddr [$];
        bit expLoad [$];

        n       = (len > DEPTH) ? DEPTH : len;
        expBusy = (n == 0) ? 0 : (isFill ? n : 2 * n);
        for (int k = 0; k < n; k++) begin
            if (isFill) begin
                expAddr.push_back((dst + k) % DEPTH);
                expLoad.push_back(1'b1);
            end else begin
                expAddr.push_back((src + k) % DEPTH);
                expLoad.push_back(1'b0);
                expAddr.push_back((dst + k) % DEPTH);
                expLoad.push_back(1'b1);
            end
        end

        @(negedge clk);
        a0 = addrQ.size();
        d0 = doneCount;
        s0 = strayLoads;
        op        = isFill;
        src_addr  = src[8:0];
        dst_addr  = dst[8:0];
        length    = len[9:0];
        fill_data = fv;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        op        = 1'($urandom);
        src_addr  = 9'($urandom);
        dst_addr  = 9'($urandom);
        length    = 10'($urandom);
        fill_data = 16'($urandom);

        waitCycles = 1;
        seen       = 1'b0;
        while (!seen && waitCycles < 3000) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (pokeMid && waitCycles == 2) begin
                    op       = 1'b1;
                    dst_addr = 9'd0;
                    length   = 10'd7;
                    start    = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                waitCycles++;
            end
        end
        start = 1'b0;

        checkOutput({name, " done_seen"}, 32'(seen), 32'd1);
        checkOutput({name, " latency"}, waitCycles, expBusy + 1);
        checkOutput({name, " words_done"}, 32'(words_done), n);
        checkOutput({name, " busy_in_done"}, 32'(busy), 32'd0);
        checkOutput({name, " load_in_done"}, 32'(mem_load), 32'd0);

        // Reference model: words are moved one at a time in ascending order,
        // so an overlapping forward copy replicates the leading words.
        for (int k = 0; k < n; k++) begin
            if (isFill) begin
                refMem[(dst + k) % DEPTH] = fv;
            end else begin
                refMem[(dst + k) % DEPTH] = refMem[(src + k) % DEPTH];
            end
        end

        @(negedge clk);
        checkOutput({name, " done_pulse_width"}, 32'(done), 32'd0);
        checkOutput({name, " words_done_hold"}, 32'(words_done), n);
        @(negedge clk);
        checkOutput({name, " idle_after"}, 32'(busy), 32'd0);
        checkOutput({name, " done_count"}, doneCount - d0, 1);
        checkOutput({name, " stray_loads"}, strayLoads - s0, 0);
        checkOutput({name, " busy_cycles"}, addrQ.size() - a0, expBusy);

        nTrace = addrQ.size() - a0;
        if (nTrace > expBusy) begin
            nTrace = expBusy;
        end
        for (int k = 0; k < nTrace; k++) begin
            checkOutput($sformatf("%s addr[%0d]", name, k), 32'(addrQ[a0 + k]), expAddr[k]);
            checkOutput($sformatf("%s load[%0d]", name, k), 32'(loadQ[a0 + k]), 32'(expLoad[k]));
        end
        checkMemory(name);
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, " busy"}, 32'(busy), 32'd0);
        checkOutput({name, " done"}, 32'(done), 32'd0);
        checkOutput({name, " mem_load"}, 32'(mem_load), 32'd0);
        checkOutput({name, " mem_address"}, 32'(mem_address), 32'd0);
        checkOutput({name, " mem_in"}, 32'(mem_in), 32'd0);
        checkOutput({name, " words_done"}, 32'(words_done), 32'd0);
    endtask

    initial begin
        int rsel;
        int rlen;
        logic [15:0] rfv;

        reset     = 1'b1;
        start     = 1'b0;
        op        = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        length    = '0;
        fill_data = '0;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        reset = 1'b0;

        preloadRandom();

        applyStimulus("fill10x4", 1'b1, 0, 10, 4, 16'hBEEF, 1'b0);

        pokeWord(0, 16'd1);
        pokeWord(1, 16'd2);
        pokeWord(2, 16'd3);
        applyStimulus("copy0to100", 1'b0, 0, 100, 3, 16'h0000, 1'b0);

        applyStimulus("fill_wrap", 1'b1, 0, 510, 4, 16'h0007, 1'b0);
        applyStimulus("copy_wrap", 1'b0, 511, 5, 2, 16'h0000, 1'b0);

        applyStimulus("fill_len0", 1'b1, 0, 40, 0, 16'h1234, 1'b0);
        applyStimulus("copy_len0", 1'b0, 7, 40, 0, 16'h0000, 1'b0);
        applyStimulus("fill_len600", 1'b1, 0, 77, 600, 16'h5A5A, 1'b0);

        pokeWord(20, 16'h000A);
        applyStimulus("copy_overlap", 1'b0, 20, 21, 3, 16'h0000, 1'b1);

        // Reset in the third cycle of a 5-word fill: the start cycle, then
        // two write cycles, the second of which still commits at the edge
        // where reset is sampled.
        @(negedge clk);
        op        = 1'b1;
        dst_addr  = 9'd300;
        length    = 10'd5;
        fill_data = 16'hC0DE;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("rst_mid busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkResetState("rst_mid");
        reset = 1'b0;
        refMem[300] = 16'hC0DE;
        refMem[301] = 16'hC0DE;
        @(negedge clk);
        checkMemory("rst_mid");

        for (int t = 0; t < 20; t++) begin
            rsel = $urandom_range(0, 9);
            if (rsel == 0) begin
                rlen = 0;
            end else if (rsel == 1) begin
                rlen = $urandom_range(513, 1023);
            end else if (rsel == 2) begin
                rlen = 512;
            end else begin
                rlen = $urandom_range(1, 40);
            end
            rfv = 16'($urandom);
            applyStimulus($sformatf("rand%0d", t), 1'($urandom), $urandom_range(0, 511),
                          $urandom_range(0, 511), rlen, rfv, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
